// File: rtl/mac_array_arbiter_if.sv
// Requester-side and MAC-array-side signals of the shared MAC array arbiter.
// The slave modport is the arbiter view; the master modport drives requesters and the array.
interface mac_array_arbiter_if #(
  parameter int NUM_REQ         = 3,
  parameter int PARALLEL_FACTOR = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int LEN_WIDTH       = 10
);
  localparam int BW = PARALLEL_FACTOR * DATA_WIDTH;

  logic [NUM_REQ-1:0]           i_req;
  logic [NUM_REQ*LEN_WIDTH-1:0] i_req_len;
  logic [NUM_REQ-1:0]           o_grant;
  logic [NUM_REQ-1:0]           i_beat_valid;
  logic [NUM_REQ-1:0]           o_beat_ready;
  logic [NUM_REQ*BW-1:0]        i_act;
  logic [NUM_REQ*BW-1:0]        i_wgt;
  logic                         o_mac_valid;
  logic                         i_mac_ready;
  logic [BW-1:0]                o_mac_act;
  logic [BW-1:0]                o_mac_wgt;
  logic                         o_mac_first;
  logic                         o_mac_last;
  logic [NUM_REQ-1:0]           o_done;
  logic                         o_busy;

  modport slave (
    input  i_req, i_req_len, i_beat_valid, i_act, i_wgt, i_mac_ready,
    output o_grant, o_beat_ready, o_mac_valid, o_mac_act, o_mac_wgt,
           o_mac_first, o_mac_last, o_done, o_busy
  );

  modport master (
    output i_req, i_req_len, i_beat_valid, i_act, i_wgt, i_mac_ready,
    input  o_grant, o_beat_ready, o_mac_valid, o_mac_act, o_mac_wgt,
           o_mac_first, o_mac_last, o_done, o_busy
  );
endinterface

// File: rtl/mac_array_arbiter.sv
// Job-level arbiter sharing one MAC array; MAC_ARB_RR_EN selects round-robin, else highest index wins.
// Latency: grant 1 cycle after request, beats pass through combinationally, 2 dead cycles between jobs.
// Backpressure: i_mac_ready is forwarded only to the granted requester; others see ready low.
module mac_array_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int PARALLEL_FACTOR = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int LEN_WIDTH       = 10
) (
  input logic             clk,
  input logic             rst_n,
  mac_array_arbiter_if.slave bus
);
  localparam int BW = PARALLEL_FACTOR * DATA_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic [IW-1:0]        r_gidx;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_busy;
`ifdef MAC_ARB_RR_EN
  logic [IW-1:0]        r_ptr;
  int                   w_rr_pos;
`endif

  logic                 w_win_vld;
  logic [IW-1:0]        w_win_idx;
  logic                 w_in_busy;
  logic                 w_zero_len;
  logic                 w_mac_valid;
  logic                 w_accept;
  logic                 w_last_beat;
  logic [BW-1:0]        w_act;
  logic [BW-1:0]        w_wgt;

  always_comb begin
    w_win_vld = |bus.i_req;
    w_win_idx = '0;
`ifdef MAC_ARB_RR_EN
    // Walk from the farthest offset down so the requester nearest the pointer wins.
    w_rr_pos = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_rr_pos = int'(r_ptr) + i;
      if (w_rr_pos >= NUM_REQ) w_rr_pos = w_rr_pos - NUM_REQ;
      if (bus.i_req[w_rr_pos]) w_win_idx = IW'(w_rr_pos);
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.i_req[i]) w_win_idx = IW'(i);
    end
`endif
  end

  always_comb begin
    w_in_busy   = (r_state == BUSY);
    w_zero_len  = (r_len == '0);
    w_act       = bus.i_act[int'(r_gidx)*BW +: BW];
    w_wgt       = bus.i_wgt[int'(r_gidx)*BW +: BW];
    w_mac_valid = w_in_busy && !w_zero_len && bus.i_beat_valid[r_gidx];
    w_accept    = w_mac_valid && bus.i_mac_ready;
    w_last_beat = (r_cnt == r_len - LEN_WIDTH'(1));
  end

  // r_grant is zero outside BUSY, so it doubles as the ready steering mask.
  assign bus.o_beat_ready = r_grant & {NUM_REQ{bus.i_mac_ready}};
  assign bus.o_mac_valid  = w_mac_valid;
  assign bus.o_mac_act    = w_in_busy ? w_act : '0;
  assign bus.o_mac_wgt    = w_in_busy ? w_wgt : '0;
  assign bus.o_mac_first  = w_in_busy && (r_cnt == '0);
  assign bus.o_mac_last   = w_in_busy && w_last_beat;
  assign bus.o_grant      = r_grant;
  assign bus.o_done       = r_done;
  assign bus.o_busy       = r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_gidx  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
`ifdef MAC_ARB_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_grant <= NUM_REQ'(1) << w_win_idx;
            r_gidx  <= w_win_idx;
            r_len   <= bus.i_req_len[int'(w_win_idx)*LEN_WIDTH +: LEN_WIDTH];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // A zero-length job retires after its single BUSY cycle.
          if (w_zero_len || (w_accept && w_last_beat)) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_state <= RELEASE;
          end else if (w_accept) begin
            r_cnt <= r_cnt + LEN_WIDTH'(1);
          end
        end
        RELEASE: begin
`ifdef MAC_ARB_RR_EN
          r_ptr <= (int'(r_gidx) == NUM_REQ - 1) ? '0 : r_gidx + IW'(1);
`endif
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_array_arbiter.sv
// Directed bench for mac_array_arbiter: job-level reference model checked every cycle,
// plus hand-computed traces and counts per scenario.
module tb_mac_array_arbiter;
  localparam int N  = 3;
  localparam int PF = 8;
  localparam int DW = 8;
  localparam int LW = 10;
  localparam int BW = PF * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] beat_valid;
  logic         mac_ready;
  int           lenv    [N];
  int           rq_beat [N];

  mac_array_arbiter_if #(.NUM_REQ(N), .PARALLEL_FACTOR(PF), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  mac_array_arbiter #(.NUM_REQ(N), .PARALLEL_FACTOR(PF), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [BW-1:0] beat_data(int k, int b, bit inv);
    logic [BW-1:0] d;
    for (int l = 0; l < PF; l++) d[l*DW +: DW] = DW'(k*64 + b*8 + l) ^ {DW{inv}};
    return d;
  endfunction

  assign bus.i_req        = req;
  assign bus.i_beat_valid = beat_valid;
  assign bus.i_mac_ready  = mac_ready;

  always_comb begin
    bus.i_req_len = '0;
    bus.i_act     = '0;
    bus.i_wgt     = '0;
    for (int k = 0; k < N; k++) begin
      bus.i_req_len[k*LW +: LW] = LW'(lenv[k]);
      bus.i_act[k*BW +: BW]     = beat_data(k, rq_beat[k], 1'b0);
      bus.i_wgt[k*BW +: BW]     = beat_data(k, rq_beat[k], 1'b1);
    end
  end

  // Job-level model: who owns the array, how long the job is, how many beats went through.
  int m_owner = -1;
  int m_len   = 0;
  int m_acc   = 0;
  int m_rel   = -1;
`ifdef MAC_ARB_RR_EN
  int m_rr    = 0;
`endif

  int errors = 0;
  int checks = 0;

  logic [9:0]   trace [$];
  logic [7:0]   act0  [$];
  logic [N-1:0] glog  [$];
  logic [N-1:0] prev_grant = '0;
  int n_acc, n_last_acc, last_ord, n_valid;
  int n_gcyc [N];
  int n_done [N];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    int w = -1;
`ifdef MAC_ARB_RR_EN
    for (int off = 0; off < N; off++)
      if (w < 0 && req[(m_rr + off) % N]) w = (m_rr + off) % N;
`else
    for (int k = N - 1; k >= 0; k--)
      if (w < 0 && req[k]) w = k;
`endif
    return w;
  endfunction

  task automatic compare_and_model();
    logic [N-1:0]  eg, er, ed;
    logic          ev, ef, el, eb, acc;
    logic [BW-1:0] ea, ew;
    int            w;
    eg = '0; er = '0; ed = '0; ea = '0; ew = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      er[m_owner] = mac_ready;
      ea = beat_data(m_owner, rq_beat[m_owner], 1'b0);
      ew = beat_data(m_owner, rq_beat[m_owner], 1'b1);
    end
    ev = (m_owner >= 0) && (m_len != 0) && beat_valid[m_owner];
    ef = (m_owner >= 0) && (m_acc == 0);
    el = (m_owner >= 0) && (m_acc == m_len - 1);
    if (m_rel >= 0) ed[m_rel] = 1'b1;
    eb = (m_owner >= 0) || (m_rel >= 0);

    chk("grant",      bus.o_grant,      eg);
    chk("beat_ready", bus.o_beat_ready, er);
    chk("mac_valid",  bus.o_mac_valid,  ev);
    chk("mac_act",    bus.o_mac_act,    ea);
    chk("mac_wgt",    bus.o_mac_wgt,    ew);
    chk("mac_first",  bus.o_mac_first,  ef);
    chk("mac_last",   bus.o_mac_last,   el);
    chk("done",       bus.o_done,       ed);
    chk("busy",       bus.o_busy,       eb);

    // Observation log for the hand-computed scenario expectations.
    acc = bus.o_mac_valid && mac_ready;
    trace.push_back({bus.o_grant, acc, bus.o_mac_first, bus.o_mac_last, bus.o_done, bus.o_busy});
    act0.push_back(bus.o_mac_act[7:0]);
    if (bus.o_grant != '0 && prev_grant == '0) glog.push_back(bus.o_grant);
    prev_grant = bus.o_grant;
    if (acc) n_acc++;
    if (acc && bus.o_mac_last) begin n_last_acc++; last_ord = n_acc; end
    if (bus.o_mac_valid) n_valid++;
    for (int k = 0; k < N; k++) begin
      if (bus.o_grant[k]) n_gcyc[k]++;
      if (bus.o_done[k])  n_done[k]++;
    end

    if (!rst_n) begin
      m_owner = -1; m_rel = -1;
`ifdef MAC_ARB_RR_EN
      m_rr = 0;
`endif
    end else if (m_owner >= 0) begin
      if (m_len == 0 || (ev && mac_ready && m_acc == m_len - 1)) begin
        m_rel = m_owner; m_owner = -1;
      end else if (ev && mac_ready) begin
        m_acc++;
      end
    end else if (m_rel >= 0) begin
`ifdef MAC_ARB_RR_EN
      m_rr = (m_rel + 1) % N;
`endif
      m_rel = -1;
    end else begin
      w = pick();
      if (w >= 0) begin m_owner = w; m_len = lenv[w]; m_acc = 0; end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = bus.o_beat_ready & beat_valid;
    compare_and_model();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (hs[k]) rq_beat[k]++;
  endtask

  task automatic clear();
    trace.delete(); act0.delete(); glog.delete();
    n_acc = 0; n_last_acc = 0; last_ord = 0; n_valid = 0;
    for (int k = 0; k < N; k++) begin n_gcyc[k] = 0; n_done[k] = 0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
  endtask

  logic [9:0]   exp_t1 [7];
  logic [N-1:0] exp_g  [4];
  logic [N-1:0] exp_after_rst;
  logic [9:0]   t;

  initial begin
    rst_n = 1'b0; req = '0; beat_valid = '0; mac_ready = 1'b0;
    for (int k = 0; k < N; k++) begin lenv[k] = 0; rq_beat[k] = 0; end
    clear();
    @(posedge clk); #1;
    repeat (2) cycle();
    chk("reset_grant", bus.o_grant, 0);
    chk("reset_busy",  bus.o_busy, 0);
    chk("reset_valid", bus.o_mac_valid, 0);
    chk("reset_done",  bus.o_done, 0);
    rst_n = 1'b1; beat_valid = '1; mac_ready = 1'b1;

    // Single job, requester 0, four beats.
    exp_t1 = '{10'b000_0_0_0_000_0, 10'b001_1_1_0_000_1, 10'b001_1_0_0_000_1,
               10'b001_1_0_0_000_1, 10'b001_1_0_1_000_1, 10'b000_0_0_0_001_1,
               10'b000_0_0_0_000_0};
    clear(); req = 3'b001; lenv[0] = 4;
    cycle(); req = '0;
    repeat (6) cycle();
    for (int i = 0; i < 7; i++) chk($sformatf("single_trace[%0d]", i), trace[i], exp_t1[i]);
    chk("single_done0", n_done[0], 1);

    // Contention with all three requesting, two beats each.
    do_reset();
    clear(); req = 3'b111; lenv[0] = 2; lenv[1] = 2; lenv[2] = 2;
    repeat (16) cycle();
    req = '0;
    repeat (4) cycle();
`ifdef MAC_ARB_RR_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_g = '{3'b100, 3'b100, 3'b100, 3'b100};
`endif
    chk("contention_jobs", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("contention_grant[%0d]", i), glog[i], exp_g[i]);

    // Backpressure: len 3, ready toggling while beats are offered.
    clear(); rq_beat[0] = 0; req = 3'b001; lenv[0] = 3;
    cycle(); req = '0;
    for (int i = 0; i < 5; i++) begin mac_ready = (i % 2 == 0); cycle(); end
    mac_ready = 1'b1;
    repeat (3) cycle();
    chk("bp_accepts",     n_acc, 3);
    chk("bp_last_count",  n_last_acc, 1);
    chk("bp_last_is_3rd", last_ord, 3);
    chk("bp_stall_act_a", act0[2], 8'd8);
    chk("bp_stall_act_b", act0[3], 8'd8);
    chk("bp_stall_act_c", act0[4], 8'd16);
    chk("bp_stall_act_d", act0[5], 8'd16);
    chk("bp_done0",       n_done[0], 1);

    // Zero-length job from requester 1.
    clear(); req = 3'b010; lenv[1] = 0;
    cycle(); req = '0;
    repeat (4) cycle();
    chk("zero_grant_cycles", n_gcyc[1], 1);
    chk("zero_valid_cycles", n_valid, 0);
    chk("zero_done1",        n_done[1], 1);
    chk("zero_grant_c1",     trace[1][9:7], 3'b010);
    chk("zero_done_c2",      trace[2][3:1], 3'b010);

    // Reset during beat 2 of a six-beat job, then a fresh three-way request.
    clear(); req = 3'b010; lenv[1] = 6; lenv[0] = 2; lenv[2] = 2;
    cycle(); req = '0;
    cycle(); cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; req = 3'b111; cycle();
    req = '0;
    repeat (6) cycle();
`ifdef MAC_ARB_RR_EN
    exp_after_rst = 3'b001;
`else
    exp_after_rst = 3'b100;
`endif
    chk("rst_outputs_zero", trace[4], 10'b0);
    chk("rst_no_done1",     n_done[1], 0);
    t = trace[5];
    chk("rst_next_grant",   t[9:7], exp_after_rst);

    // Requester 2 withdraws its request after beat 1; the job still runs to 5 beats.
    clear(); req = 3'b100; lenv[2] = 5;
    cycle(); cycle(); cycle();
    req = '0;
    repeat (6) cycle();
    chk("withdraw_grant_cycles", n_gcyc[2], 5);
    chk("withdraw_accepts",      n_acc, 5);
    chk("withdraw_done2",        n_done[2], 1);
    chk("withdraw_grant_c5",     trace[5][9:7], 3'b100);
    chk("withdraw_done_c6",      trace[6][3:1], 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule
